// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Parametrised, pipelined carry-lookahead adder. The WIDTH-bit operands are
//   split into STAGES slices of BLK = WIDTH/STAGES bits. Stage k adds slice k
//   using 4-bit lookahead groups and registers the carry for stage k+1.
//   A single global advance signal moves the whole pipeline, so backpressure
//   freezes every stage, including the partial sums and delayed operands.
//
// Parameters
//   WIDTH   operand / sum width (default 32)
//   STAGES  pipeline depth; WIDTH must be a multiple of STAGES (default 4)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (= !out_valid || out_ready)
//   a, b, cin  operands and carry in
//   sub        (CLA_SUB_EN only) 1 selects a - b; cin is ignored
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1 (no-borrow flag when subtracting)
//   ovf        signed overflow: carry into MSB xor carry out of MSB
//
// Optional feature
//   `define CLA_SUB_EN adds the sub port and subtraction support.

module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int BLK  = WIDTH / STAGES;
  localparam int NGRP = (BLK + 3) / 4;
  localparam int GW   = 4 * NGRP;

  if (WIDTH % STAGES != 0) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  // One slice of lookahead addition. Returns {carry out, carry into slice MSB, sum}.
  // Carries inside each 4-bit group come from flattened lookahead terms; groups
  // are chained through their group generate/propagate.
  function automatic logic [BLK+1:0] cla_slice(input logic [BLK-1:0] x,
                                                input logic [BLK-1:0] y,
                                                input logic           ci);
    logic [GW-1:0] g;
    logic [GW-1:0] p;
    logic [GW:0]   c;
    logic          gg;
    logic          gp;
    g = '0;
    p = '0;
    g[BLK-1:0] = x & y;
    p[BLK-1:0] = x ^ y;
    c = '0;
    c[0] = ci;
    for (int unsigned j = 0; j < NGRP; j++) begin
      c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
      gg = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
         | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
      c[4*j+4] = gg | (gp & c[4*j]);
    end
    return {c[BLK], c[BLK-1], p[BLK-1:0] ^ c[BLK-1:0]};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Per-stage registers. Operands are kept right-aligned (the next slice to
  // add sits in the low BLK bits); the sum is built from the top down so the
  // first slice lands in bits [BLK-1:0] after the last stage.
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic             ovf_q;

  logic             v_src [STAGES];
  logic             c_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];

  logic             v_d [STAGES];
  logic             c_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [BLK+1:0]   r   [STAGES];

`ifdef CLA_SUB_EN
  always_comb begin
    b_eff = sub ? ~b : b;
    c_eff = sub | cin;
  end
`else
  always_comb begin
    b_eff = b;
    c_eff = cin;
  end
`endif

  always_comb begin
    adv       = !v_q[STAGES-1] || out_ready;
    in_ready  = adv;
    out_valid = v_q[STAGES-1];
    sum       = s_q[STAGES-1];
    cout      = c_q[STAGES-1];
    ovf       = ovf_q;
  end

  always_comb begin
    logic [WIDTH-1:0] ext;
    a_src[0] = a;
    b_src[0] = b_eff;
    s_src[0] = '0;
    c_src[0] = c_eff;
    v_src[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = v_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      r[k] = cla_slice(a_src[k][BLK-1:0], b_src[k][BLK-1:0], c_src[k]);
      ext = '0;
      ext[BLK-1:0] = r[k][BLK-1:0];
      v_d[k] = v_src[k];
      c_d[k] = r[k][BLK+1];
      a_d[k] = a_src[k] >> BLK;
      b_d[k] = b_src[k] >> BLK;
      s_d[k] = (s_src[k] >> BLK) | (ext << (WIDTH - BLK));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        s_q[k] <= '0;
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        s_q[k] <= s_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
      ovf_q <= r[STAGES-1][BLK+1] ^ r[STAGES-1][BLK];
    end
  end

endmodule
